// File: rtl/chr_bg_fill_ctrl.sv
// Write-port mux for the chr_bg name-table RAM: CPU byte writes plus a rectangle-fill engine.
// Latency: 1 cycle from deciding edge to chr_* outputs. CPU writes win; the fill stalls and never drops a cell.
module chr_bg_fill_ctrl #(
    parameter int CHR_SIZE_BITS = 6,
    parameter int DATA_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             cpu_address,
    input  logic [DATA_WIDTH-1:0]   cpu_din,
    input  logic                    cpu_we,
    input  logic                    fill_start,
    input  logic                    fill_abort,
    input  logic [CHR_SIZE_BITS-1:0] fill_x,
    input  logic [CHR_SIZE_BITS-1:0] fill_y,
    input  logic [CHR_SIZE_BITS:0]  fill_w,
    input  logic [CHR_SIZE_BITS:0]  fill_h,
    input  logic [DATA_WIDTH-1:0]   fill_value,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             chr_address,
    output logic [DATA_WIDTH-1:0]   chr_din,
    output logic                    chr_we
);
    localparam int CSB = CHR_SIZE_BITS;
    localparam int AW  = 2 * CHR_SIZE_BITS;
    localparam logic [CSB:0] MAP_DIM = (CSB+1)'(2 ** CSB);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [CSB-1:0]        x_q, x_d, y_q, y_d;
    logic [CSB:0]          w_q, w_d, h_q, h_d;
    logic [DATA_WIDTH-1:0] val_q, val_d;
    logic [CSB-1:0]        col_q, col_d, row_q, row_d;
    logic                  busy_q, busy_d, done_q, done_d, we_q, we_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;

    logic [CSB:0]   w_clamp, h_clamp;
    logic [CSB-1:0] cell_x, cell_y;
    logic           last_col, last_row;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^cpu_address[31:AW];

    assign w_clamp  = (fill_w > MAP_DIM) ? MAP_DIM : fill_w;
    assign h_clamp  = (fill_h > MAP_DIM) ? MAP_DIM : fill_h;
    // Sums truncate to CSB bits, so rectangles wrap around the map edges.
    assign cell_x   = x_q + col_q;
    assign cell_y   = y_q + row_q;
    assign last_col = ({1'b0, col_q} == (w_q - 1'b1));
    assign last_row = ({1'b0, row_q} == (h_q - 1'b1));

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        w_d     = w_q;
        h_d     = h_q;
        val_d   = val_q;
        col_d   = col_q;
        row_d   = row_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        din_d   = din_q;

        if (cpu_we) begin
            we_d   = 1'b1;
            addr_d = cpu_address[AW-1:0];
            din_d  = cpu_din;
        end

        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    x_d     = fill_x;
                    y_d     = fill_y;
                    w_d     = w_clamp;
                    h_d     = h_clamp;
                    val_d   = fill_value;
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                    state_d = (w_clamp == '0 || h_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // A CPU write steals the port; counters hold and abort waits.
                if (!cpu_we) begin
                    if (fill_abort) begin
                        state_d = DONE;
                    end else begin
                        we_d   = 1'b1;
                        din_d  = val_q;
                        addr_d = {cell_y, cell_x};
                        if (last_col) begin
                            col_d = '0;
                            row_d = row_q + 1'b1;
                            if (last_row) begin
                                state_d = DONE;
                            end
                        end else begin
                            col_d = col_q + 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            val_q   <= '0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            w_q     <= w_d;
            h_q     <= h_d;
            val_q   <= val_d;
            col_q   <= col_d;
            row_q   <= row_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign chr_we      = we_q;
    assign chr_din     = din_q;
    assign chr_address = {{(32-AW){1'b0}}, addr_q};
endmodule

// File: tb/tb_chr_bg_fill_ctrl.sv
// Directed bench for chr_bg_fill_ctrl: basic, wrap, contention, degenerate, abort and reset cases.
module tb_chr_bg_fill_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] cpu_address = '0;
    logic [7:0]  cpu_din = '0;
    logic        cpu_we = 1'b0;
    logic        fill_start = 1'b0;
    logic        fill_abort = 1'b0;
    logic [5:0]  fill_x = '0;
    logic [5:0]  fill_y = '0;
    logic [6:0]  fill_w = '0;
    logic [6:0]  fill_h = '0;
    logic [7:0]  fill_value = '0;
    logic        busy, done, chr_we;
    logic [31:0] chr_address;
    logic [7:0]  chr_din;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    int basic_a[6] = '{194, 195, 196, 258, 259, 260};
    int wrap_a[8]  = '{4094, 4095, 4032, 4033, 62, 63, 0, 1};
    int cont_a[9]  = '{194, 195, 10, 10, 10, 196, 258, 259, 260};
    int cont_d[9]  = '{8'h41, 8'h41, 8'h55, 8'h55, 8'h55, 8'h41, 8'h41, 8'h41, 8'h41};

    chr_bg_fill_ctrl #(.CHR_SIZE_BITS(6), .DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset),
        .cpu_address(cpu_address), .cpu_din(cpu_din), .cpu_we(cpu_we),
        .fill_start(fill_start), .fill_abort(fill_abort),
        .fill_x(fill_x), .fill_y(fill_y), .fill_w(fill_w), .fill_h(fill_h),
        .fill_value(fill_value),
        .busy(busy), .done(done),
        .chr_address(chr_address), .chr_din(chr_din), .chr_we(chr_we)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_wr(input string tag, input int addr, input int data);
        chk({tag, " we"}, {31'd0, chr_we}, 32'd1);
        chk({tag, " addr"}, chr_address, addr);
        chk({tag, " din"}, {24'd0, chr_din}, data);
    endtask

    task automatic start_fill(input int x, input int y, input int w, input int h, input int v);
        fill_x     = 6'(x);
        fill_y     = 6'(y);
        fill_w     = 7'(w);
        fill_h     = 7'(h);
        fill_value = 8'(v);
        fill_start = 1'b1;
        tick();
        fill_start = 1'b0;
    endtask

    initial begin
        int wr_count;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst we", {31'd0, chr_we}, 0);
        chk("rst busy", {31'd0, busy}, 0);
        chk("rst done", {31'd0, done}, 0);
        chk("rst addr", chr_address, 0);
        chk("rst din", {24'd0, chr_din}, 0);
        reset = 1'b1;
        tick();

        // Basic fill
        start_fill(2, 3, 3, 2, 8'h41);
        chk("basic busy at accept", {31'd0, busy}, 1);
        chk("basic no write at accept", {31'd0, chr_we}, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            expect_wr($sformatf("basic cell%0d", i), basic_a[i], 8'h41);
            chk($sformatf("basic busy%0d", i), {31'd0, busy}, 1);
        end
        tick();
        chk("basic end we", {31'd0, chr_we}, 0);
        chk("basic done", {31'd0, done}, 1);
        chk("basic busy low", {31'd0, busy}, 0);
        chk("basic addr hold", chr_address, 260);
        tick();
        chk("basic done one cycle", {31'd0, done}, 0);

        // Wrap fill, with a start request while busy that must be ignored
        start_fill(62, 63, 4, 2, 8'h07);
        for (int i = 0; i < 8; i++) begin
            if (i == 2) begin
                fill_x = 6'd0; fill_y = 6'd0; fill_w = 7'd1; fill_h = 7'd1;
                fill_start = 1'b1;
            end
            tick();
            fill_start = 1'b0;
            expect_wr($sformatf("wrap cell%0d", i), wrap_a[i], 8'h07);
        end
        tick();
        chk("wrap done", {31'd0, done}, 1);
        tick();
        chk("wrap no queued start we", {31'd0, chr_we}, 0);
        chk("wrap no queued start busy", {31'd0, busy}, 0);

        // CPU contention
        start_fill(2, 3, 3, 2, 8'h41);
        wr_count = 0;
        for (int i = 0; i < 9; i++) begin
            if (i == 2) begin
                cpu_we = 1'b1; cpu_address = 32'd10; cpu_din = 8'h55;
            end
            if (i == 5) cpu_we = 1'b0;
            tick();
            if (chr_we) wr_count++;
            expect_wr($sformatf("cont cycle%0d", i), cont_a[i], cont_d[i]);
        end
        cpu_we = 1'b0;
        tick();
        chk("cont write count", wr_count, 9);
        chk("cont done", {31'd0, done}, 1);
        chk("cont end we", {31'd0, chr_we}, 0);
        tick();

        // Degenerate: zero width
        start_fill(0, 0, 0, 5, 8'h99);
        chk("w0 busy at accept", {31'd0, busy}, 1);
        tick();
        chk("w0 done", {31'd0, done}, 1);
        chk("w0 busy low", {31'd0, busy}, 0);
        chk("w0 no write", {31'd0, chr_we}, 0);
        tick();
        chk("w0 done one cycle", {31'd0, done}, 0);

        // Degenerate: width clamped to map size
        start_fill(0, 0, 100, 1, 8'hAA);
        wr_count = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (chr_we === 1'b1 && chr_address == 32'(i) && chr_din == 8'hAA) wr_count++;
        end
        tick();
        chk("clamp good writes", wr_count, 64);
        chk("clamp end we", {31'd0, chr_we}, 0);
        chk("clamp done", {31'd0, done}, 1);
        tick();

        // Abort after 5 writes
        start_fill(0, 0, 8, 8, 8'h20);
        for (int i = 0; i < 5; i++) begin
            tick();
            expect_wr($sformatf("abort cell%0d", i), i, 8'h20);
        end
        fill_abort = 1'b1;
        tick();
        fill_abort = 1'b0;
        chk("abort no write", {31'd0, chr_we}, 0);
        chk("abort busy still", {31'd0, busy}, 1);
        chk("abort done not yet", {31'd0, done}, 0);
        tick();
        chk("abort done", {31'd0, done}, 1);
        chk("abort busy low", {31'd0, busy}, 0);
        chk("abort done no write", {31'd0, chr_we}, 0);
        tick();

        // Restart, then simultaneous CPU write and abort
        start_fill(5, 5, 2, 1, 8'h7E);
        tick();
        expect_wr("restart cell0", 325, 8'h7E);
        cpu_we = 1'b1; cpu_address = 32'd20; cpu_din = 8'h33; fill_abort = 1'b1;
        tick();
        cpu_we = 1'b0;
        expect_wr("cpu beats abort", 20, 8'h33);
        tick();
        fill_abort = 1'b0;
        chk("held abort no write", {31'd0, chr_we}, 0);
        chk("held abort busy", {31'd0, busy}, 1);
        tick();
        chk("held abort done", {31'd0, done}, 1);
        tick();

        // Reset mid-fill
        start_fill(0, 0, 8, 8, 8'h11);
        repeat (3) tick();
        chk("pre-reset we", {31'd0, chr_we}, 1);
        reset = 1'b0;
        #1;
        chk("midrst we", {31'd0, chr_we}, 0);
        chk("midrst busy", {31'd0, busy}, 0);
        chk("midrst done", {31'd0, done}, 0);
        chk("midrst addr", chr_address, 0);
        #2;
        reset = 1'b1;
        wr_count = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (chr_we !== 1'b0 || done !== 1'b0 || busy !== 1'b0) wr_count++;
        end
        chk("post-reset quiet", wr_count, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/chr_bg_fill_ctrl.md
Name: chr_bg_fill_ctrl

Overview:
- Write-port controller for the chr_bg character (name-table) RAM. It sits in the `clk` domain between the CPU bus and chr_bg's `chr_address`/`chr_din`/`chr_we` inputs.
- It merges CPU single-byte writes with a hardware rectangle-fill engine, which clears or sets character regions without CPU loops.
- CPU writes have strict priority. The fill engine stalls on contention and never drops a cell.

Parameters:
- CHR_SIZE_BITS, 6, log2 of map width/height in characters; map is 2^CHR_SIZE_BITS square.
- DATA_WIDTH, 8, character code width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_address  in  32  CPU write address; low 2*CHR_SIZE_BITS bits used.
- cpu_din  in  DATA_WIDTH  CPU write data.
- cpu_we  in  1  CPU write strobe, one write per cycle high.
- fill_start  in  1  single-cycle start pulse; fill parameters sampled with it.
- fill_abort  in  1  terminates a running fill.
- fill_x  in  CHR_SIZE_BITS  rectangle left column.
- fill_y  in  CHR_SIZE_BITS  rectangle top row.
- fill_w  in  CHR_SIZE_BITS+1  width in cells.
- fill_h  in  CHR_SIZE_BITS+1  height in cells.
- fill_value  in  DATA_WIDTH  code written to every cell.
- busy  out  1  fill accepted and not yet finished.
- done  out  1  one-cycle pulse when a fill completes or aborts.
- chr_address  out  32  to chr_bg; zero-extended 2*CHR_SIZE_BITS-bit address.
- chr_din  out  DATA_WIDTH  to chr_bg.
- chr_we  out  1  to chr_bg.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - chr_we=0, chr_address=0, chr_din=0, busy=0, done=0.
  - Row and column counters are cleared.
  - Reset mid-fill abandons the fill with no done pulse.
- All outputs are registered. A write is visible on chr_* exactly 1 cycle after the edge that decides it.
- States are IDLE, RUN and DONE.
- IDLE:
  - fill_start=1 latches x, y, value, w and h. Widths/heights greater than 2^CHR_SIZE_BITS are clamped to 2^CHR_SIZE_BITS.
  - If clamped w=0 or h=0, go to DONE.
  - Otherwise col=0, row=0, go to RUN.
  - busy rises at the accepting edge.
- RUN, per edge:
  - If cpu_we=1: forward the CPU write, fill counters hold.
  - Else if fill_abort=1: chr_we<=0, go to DONE.
  - Else: chr_we<=1, chr_din<=value, chr_address<=(((y+row) mod 2^CSB)<<CSB) | ((x+col) mod 2^CSB).
    - Then col++. At col=w-1: col<=0, row++.
    - At row=h-1 and col=w-1: go to DONE.
- DONE: done<=1 and busy<=0 at the edge entering IDLE. DONE lasts 1 cycle, so done is high for exactly one cycle.
- CPU path in every state: cpu_we=1 gives chr_we<=1, chr_address<=cpu_address[2*CSB-1:0], chr_din<=cpu_din.
- Idle output: chr_we<=0 when there is neither a CPU write nor a fill write. chr_address/chr_din hold their previous value.
- Wrap-around: row and column sums wrap modulo map size independently. A rectangle crossing an edge continues on the opposite edge.
- fill_start while busy or in DONE is ignored; no queueing.
- fill_abort outside RUN has no effect.
- Simultaneous cpu_we and fill_abort in RUN: the CPU write is issued and the abort is taken on the next cycle without cpu_we (abort must be held).
- Fill cell order is row-major, top-left first. Each cell is written exactly once.
- Total fill cycles = w*h + number of CPU-write cycles during RUN.

Test Plan:
- Reset check: drive reset=0 mid-traffic -> chr_we=0, busy=0, done=0 immediately; release, idle 10 cycles -> no writes.
- Basic fill: x=2, y=3, w=3, h=2, value=0x41, start at edge T.
  - chr_we high on 6 consecutive cycles.
  - Addresses 194,195,196,258,259,260, data 0x41.
  - busy high from T; done single pulse the cycle after the last write, with busy low at the same edge.
- Wrap fill: x=62, y=63, w=4, h=2 -> addresses 4094,4095,4032,4033,62,63,0,1, then done.
- CPU contention: run the basic fill with cpu_we high for 3 cycles (address 10, data 0x55) starting after the 2nd fill write.
  - 3 writes to 10/0x55 are interleaved.
  - The remaining fill addresses continue at 196, none skipped; 9 write cycles in total.
- Degenerate: w=0, h=5 -> no chr_we, done pulses 1 cycle after start. w=100, h=1, x=0, y=0 -> exactly 64 writes, addresses 0..63.
- Abort: fill w=8, h=8, fill_abort pulsed after 5 writes -> no further fill writes, done one cycle later. A new start is then accepted normally.
